// File: rtl/rob_retire_if.sv
// ---------------------------------------------------------------------------
// rob_retire_if
// Handshake bundle between rename, execute, the retire consumer and the ROB.
//   alloc_* : rename -> ROB allocation (valid/ready, payload, assigned index)
//   cmpl_*  : execute -> ROB completion report (index of finished entry)
//   ret_*   : ROB -> RAT/free pool retire (valid/ready, head payload)
// Modports:
//   master : the core side (rename/execute/retire consumer)
//   slave  : the ROB itself
// ---------------------------------------------------------------------------
interface rob_retire_if #(
   parameter int IDX_W  = 4,
   parameter int AREG_W = 5,
   parameter int PREG_W = 7
);
   logic              alloc_valid;
   logic              alloc_ready;
   logic              alloc_has_rd;
   logic [AREG_W-1:0] alloc_ard;
   logic [PREG_W-1:0] alloc_pd;
   logic [PREG_W-1:0] alloc_old_pd;
   logic [IDX_W-1:0]  alloc_idx;

   logic              cmpl_valid;
   logic [IDX_W-1:0]  cmpl_idx;

   logic              ret_valid;
   logic              ret_ready;
   logic              ret_has_rd;
   logic [AREG_W-1:0] ret_ard;
   logic [PREG_W-1:0] ret_pd;
   logic [PREG_W-1:0] ret_free_preg;

   modport master (
      output alloc_valid, alloc_has_rd, alloc_ard, alloc_pd, alloc_old_pd,
      input  alloc_ready, alloc_idx,
      output cmpl_valid, cmpl_idx,
      input  ret_valid, ret_has_rd, ret_ard, ret_pd, ret_free_preg,
      output ret_ready
   );

   modport slave (
      input  alloc_valid, alloc_has_rd, alloc_ard, alloc_pd, alloc_old_pd,
      output alloc_ready, alloc_idx,
      input  cmpl_valid, cmpl_idx,
      output ret_valid, ret_has_rd, ret_ard, ret_pd, ret_free_preg,
      input  ret_ready
   );
endinterface

// File: rtl/rob_retire.sv
// ---------------------------------------------------------------------------
// rob_retire
// In-order reorder buffer with a single-entry-per-cycle retire stage.
// Rename allocates at the tail in program order, execute marks entries done
// in any order, and the head entry is presented for retire once done; the
// retired old_pd goes back to the free pool.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, discards every entry
//   bus   : rob_retire_if.slave (alloc_*, cmpl_*, ret_* handshakes)
//   count : number of occupied entries (tail - head)
// ---------------------------------------------------------------------------
module rob_retire #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int AREG_W = 5,
   parameter int PREG_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   rob_retire_if.slave      bus,
   output logic [IDX_W:0]   count
);
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0]    head_reg, head_next;
   logic [IDX_W:0]    tail_reg, tail_next;
   logic [IDX_W-1:0]  head_idx, tail_idx;
   logic              full, alloc_fire, ret_fire;

   logic [DEPTH-1:0]  valid_vec;
   logic [DEPTH-1:0]  done_vec;
   logic [DEPTH-1:0]  has_rd_vec;
   logic [AREG_W-1:0] ard_arr    [DEPTH];
   logic [PREG_W-1:0] pd_arr     [DEPTH];
   logic [PREG_W-1:0] old_pd_arr [DEPTH];

   assign head_idx   = head_reg[IDX_W-1:0];
   assign tail_idx   = tail_reg[IDX_W-1:0];
   assign full       = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);
   assign count      = tail_reg - head_reg;

   // No bypass: a retire in the same cycle does not free a slot for alloc.
   assign bus.alloc_ready = !full;
   assign bus.alloc_idx   = tail_idx;
   assign alloc_fire      = bus.alloc_valid && !full;

   assign bus.ret_valid     = valid_vec[head_idx] && done_vec[head_idx];
   assign bus.ret_has_rd    = has_rd_vec[head_idx];
   assign bus.ret_ard       = ard_arr[head_idx];
   assign bus.ret_pd        = pd_arr[head_idx];
   assign bus.ret_free_preg = old_pd_arr[head_idx];
   assign ret_fire          = bus.ret_valid && bus.ret_ready;

   always_comb begin
      head_next = head_reg;
      tail_next = tail_reg;
      if (ret_fire)   head_next = head_reg + 1'b1;
      if (alloc_fire) tail_next = tail_reg + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
      end
   end

   // One register slice per entry. Payload is cleared on reset so the ret_*
   // outputs read as zero while the buffer is empty after reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic              valid_reg, done_reg, has_rd_reg;
         logic [AREG_W-1:0] ard_reg;
         logic [PREG_W-1:0] pd_reg, old_pd_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg  <= 1'b0;
               done_reg   <= 1'b0;
               has_rd_reg <= 1'b0;
               ard_reg    <= '0;
               pd_reg     <= '0;
               old_pd_reg <= '0;
            end else if (alloc_fire && (tail_idx == IDX_W'(gi))) begin
               // Allocation overrides a same-cycle completion of this slot.
               // A slot being allocated is never the head being retired:
               // not-full with equal indices means the buffer is empty.
               valid_reg  <= 1'b1;
               done_reg   <= 1'b0;
               has_rd_reg <= bus.alloc_has_rd;
               ard_reg    <= bus.alloc_ard;
               pd_reg     <= bus.alloc_pd;
               old_pd_reg <= bus.alloc_old_pd;
            end else if (ret_fire && (head_idx == IDX_W'(gi))) begin
               valid_reg  <= 1'b0;
               done_reg   <= 1'b0;
            end else if (bus.cmpl_valid && (bus.cmpl_idx == IDX_W'(gi)) && valid_reg) begin
               done_reg   <= 1'b1;
            end
         end

         assign valid_vec[gi]  = valid_reg;
         assign done_vec[gi]   = done_reg;
         assign has_rd_vec[gi] = has_rd_reg;
         assign ard_arr[gi]    = ard_reg;
         assign pd_arr[gi]     = pd_reg;
         assign old_pd_arr[gi] = old_pd_reg;
      end
   endgenerate
endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int AREG_W = 5;
   localparam int PREG_W = 7;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [IDX_W:0] count;
   int             checks = 0;
   int             errors = 0;

   rob_retire_if #(.IDX_W(IDX_W), .AREG_W(AREG_W), .PREG_W(PREG_W)) bus ();

   rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W), .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.slave),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alloc(input logic v, input logic hr, input int ard, input int pd, input int opd);
      bus.alloc_valid  = v;
      bus.alloc_has_rd = hr;
      bus.alloc_ard    = AREG_W'(ard);
      bus.alloc_pd     = PREG_W'(pd);
      bus.alloc_old_pd = PREG_W'(opd);
   endtask

   task automatic set_cmpl(input logic v, input int idx);
      bus.cmpl_valid = v;
      bus.cmpl_idx   = IDX_W'(idx);
   endtask

   initial begin
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      set_cmpl(1'b0, 0);
      bus.ret_ready = 1'b0;

      // Reset state
      #1;
      chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
      chk("rst_alloc_idx", 32'(bus.alloc_idx), 0);
      chk("rst_ret_valid", 32'(bus.ret_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ret_pd", 32'(bus.ret_pd), 0);
      chk("rst_ret_free", 32'(bus.ret_free_preg), 0);
      #1 rst = 1'b0;
      tick();

      // 1: allocate three entries
      for (int i = 0; i < 3; i++) begin
         set_alloc(1'b1, 1'b1, i + 1, 32 + i, i + 1);
         chk("t1_alloc_idx", 32'(bus.alloc_idx), 32'(i));
         $display("t1 alloc idx=%0d ard=%0d pd=%0d", bus.alloc_idx, i + 1, 32 + i);
         tick();
      end
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      chk("t1_count", 32'(count), 3);
      chk("t1_ret_valid", 32'(bus.ret_valid), 0);

      // 2: out-of-order completion, in-order retire
      bus.ret_ready = 1'b1;
      set_cmpl(1'b1, 2);
      tick();
      chk("t2_no_ret_after_idx2", 32'(bus.ret_valid), 0);
      set_cmpl(1'b1, 0);
      tick();
      chk("t2_ret0_valid", 32'(bus.ret_valid), 1);
      chk("t2_ret0_ard", 32'(bus.ret_ard), 1);
      chk("t2_ret0_pd", 32'(bus.ret_pd), 32);
      chk("t2_ret0_free", 32'(bus.ret_free_preg), 1);
      $display("t2 retire ard=%0d pd=%0d free=%0d", bus.ret_ard, bus.ret_pd, bus.ret_free_preg);
      set_cmpl(1'b1, 1);
      tick();
      chk("t2_ret1_valid", 32'(bus.ret_valid), 1);
      chk("t2_ret1_ard", 32'(bus.ret_ard), 2);
      chk("t2_ret1_free", 32'(bus.ret_free_preg), 2);
      $display("t2 retire ard=%0d pd=%0d free=%0d", bus.ret_ard, bus.ret_pd, bus.ret_free_preg);
      set_cmpl(1'b0, 0);
      tick();
      chk("t2_ret2_valid", 32'(bus.ret_valid), 1);
      chk("t2_ret2_ard", 32'(bus.ret_ard), 3);
      chk("t2_ret2_pd", 32'(bus.ret_pd), 34);
      $display("t2 retire ard=%0d pd=%0d free=%0d", bus.ret_ard, bus.ret_pd, bus.ret_free_preg);
      tick();
      chk("t2_empty_valid", 32'(bus.ret_valid), 0);
      chk("t2_empty_count", 32'(count), 0);

      // 3: fill to full (reset first so indices start at 0)
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_alloc(1'b1, 1'b1, i, 64 + i, i);
         chk("t3_alloc_idx", 32'(bus.alloc_idx), 32'(i));
         tick();
      end
      chk("t3_full_count", 32'(count), 16);
      chk("t3_full_ready", 32'(bus.alloc_ready), 0);
      set_alloc(1'b1, 1'b1, 31, 127, 127);
      tick();
      chk("t3_17th_ignored", 32'(count), 16);
      $display("t3 full count=%0d alloc_ready=%0d", count, bus.alloc_ready);
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      set_cmpl(1'b1, 0);
      tick();
      set_cmpl(1'b0, 0);
      chk("t3_head_ret_valid", 32'(bus.ret_valid), 1);
      chk("t3_no_bypass_ready", 32'(bus.alloc_ready), 0);
      tick();
      chk("t3_ready_after_ret", 32'(bus.alloc_ready), 1);
      chk("t3_count_after_ret", 32'(count), 15);
      // Drain the rest: complete k while k-1 retires.
      for (int k = 1; k < DEPTH; k++) begin
         set_cmpl(1'b1, k);
         tick();
      end
      set_cmpl(1'b0, 0);
      tick();
      chk("t3_drained", 32'(count), 0);

      // 4: stream 40, complete one cycle after alloc; tail index starts at 0
      for (int i = 0; i < 42; i++) begin
         if (i < 40) begin
            set_alloc(1'b1, 1'b1, i % 32, (i * 3 + 5) % 128, (i + 100) % 128);
            chk("t4_alloc_idx", 32'(bus.alloc_idx), 32'(i % 16));
         end else begin
            set_alloc(1'b0, 1'b0, 0, 0, 0);
         end
         if (i >= 1 && i <= 40) set_cmpl(1'b1, (i - 1) % 16);
         else                   set_cmpl(1'b0, 0);
         chk("t4_ret_valid", 32'(bus.ret_valid), (i >= 2) ? 1 : 0);
         if (i >= 2) begin
            chk("t4_ret_pd", 32'(bus.ret_pd), 32'(((i - 2) * 3 + 5) % 128));
            chk("t4_ret_free", 32'(bus.ret_free_preg), 32'((i - 2 + 100) % 128));
            $display("t4 retire seq=%0d pd=%0d free=%0d", i - 2, bus.ret_pd, bus.ret_free_preg);
         end
         chk("t4_count_le2", 32'(count <= 2), 1);
         tick();
      end
      set_cmpl(1'b0, 0);
      chk("t4_final_count", 32'(count), 0);

      // 5: hold with ret_ready=0; 56 allocations so far puts tail at idx 8
      bus.ret_ready = 1'b0;
      set_alloc(1'b1, 1'b1, 7, 77, 9);
      chk("t5_alloc_idx", 32'(bus.alloc_idx), 8);
      tick();
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      set_cmpl(1'b1, 8);
      tick();
      set_cmpl(1'b0, 0);
      for (int c = 0; c < 5; c++) begin
         chk("t5_hold_valid", 32'(bus.ret_valid), 1);
         chk("t5_hold_pd", 32'(bus.ret_pd), 77);
         chk("t5_hold_ard", 32'(bus.ret_ard), 7);
         chk("t5_hold_count", 32'(count), 1);
         $display("t5 hold cycle=%0d pd=%0d", c, bus.ret_pd);
         tick();
      end
      bus.ret_ready = 1'b1;
      tick();
      chk("t5_one_retire_count", 32'(count), 0);
      chk("t5_one_retire_valid", 32'(bus.ret_valid), 0);

      // 6: store without rd (idx 9), then async reset with 4 live entries
      bus.ret_ready = 1'b0;
      set_alloc(1'b1, 1'b0, 0, 5, 6);
      chk("t6_sw_idx", 32'(bus.alloc_idx), 9);
      tick();
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      set_cmpl(1'b1, 9);
      tick();
      set_cmpl(1'b0, 0);
      chk("t6_sw_valid", 32'(bus.ret_valid), 1);
      chk("t6_sw_has_rd", 32'(bus.ret_has_rd), 0);
      chk("t6_sw_free", 32'(bus.ret_free_preg), 6);
      $display("t6 sw retire has_rd=%0d", bus.ret_has_rd);
      bus.ret_ready = 1'b1;
      tick();
      bus.ret_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_alloc(1'b1, 1'b1, 20 + i, 90 + i, 40 + i);
         tick();
      end
      set_alloc(1'b0, 1'b0, 0, 0, 0);
      set_cmpl(1'b1, 10);
      tick();
      set_cmpl(1'b1, 11);
      tick();
      set_cmpl(1'b0, 0);
      chk("t6_live_count", 32'(count), 4);
      chk("t6_live_valid", 32'(bus.ret_valid), 1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(bus.ret_valid), 0);
      chk("t6_async_count", 32'(count), 0);
      chk("t6_async_idx", 32'(bus.alloc_idx), 0);
      chk("t6_async_ready", 32'(bus.alloc_ready), 1);
      chk("t6_async_pd", 32'(bus.ret_pd), 0);
      $display("t6 async reset count=%0d ret_valid=%0d", count, bus.ret_valid);
      #2 rst = 1'b0;
      bus.ret_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t6_post_valid", 32'(bus.ret_valid), 0);
         chk("t6_post_count", 32'(count), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer and retire stage for the out-of-order RISC-V core.
- Rename allocates one entry per cycle in program order, carrying rd, the new physical destination pd and the previous mapping old_pd.
- Execute units mark entries complete in any order.
- Retire pops completed entries strictly in order and hands old_pd back to the free pool: the return path of rename's allocation.

Parameters:
DEPTH, 16, number of ROB entries (power of two)
IDX_W, 4, log2(DEPTH), width of ROB index
AREG_W, 5, architectural register index width (32 regs)
PREG_W, 7, physical register index width (128 regs)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
alloc_valid  in  1  rename presents an instruction
alloc_ready  out  1  ROB can accept (not full)
alloc_has_rd  in  1  instruction writes a destination (0 for SW)
alloc_ard  in  AREG_W  architectural rd
alloc_pd  in  PREG_W  newly mapped physical rd
alloc_old_pd  in  PREG_W  previous physical mapping of rd
alloc_idx  out  IDX_W  ROB index assigned to the presented instruction (= tail)
cmpl_valid  in  1  execute reports completion
cmpl_idx  in  IDX_W  ROB index completing
ret_valid  out  1  head entry is complete and presented for retire
ret_ready  in  1  RAT/free pool accepts the retire
ret_has_rd  out  1  head entry writes rd
ret_ard  out  AREG_W  head architectural rd
ret_pd  out  PREG_W  head physical rd (committed mapping)
ret_free_preg  out  PREG_W  head old_pd, to be returned to the free pool
count  out  IDX_W+1  occupied entries

Behaviour:
- Storage: circular array of DEPTH entries {valid, done, has_rd, ard, pd, old_pd}; head and tail pointers are IDX_W+1 bits with a wrap bit.
  - full = (index bits equal, wrap bits differ); empty = (head == tail).
- Reset (async, rst=1): head=tail=0, all valid/done=0.
  - Outputs: alloc_ready=1, alloc_idx=0, ret_valid=0, count=0; ret_* payload=0.
  - Reset mid-operation discards all entries; no retire is produced for them.
- Allocate: fire = alloc_valid & alloc_ready.
  - On fire at edge: entry[tail] <= {valid=1, done=0, payload}; tail <= tail+1.
  - alloc_ready = !full, combinational. It does not depend on a same-cycle retire: no bypass when full.
  - alloc_idx = tail[IDX_W-1:0], combinational, valid whenever alloc_valid is high.
- Complete: on cmpl_valid at edge, entry[cmpl_idx].done <= 1 if that entry is valid.
  - Completing an invalid entry is ignored.
  - If cmpl_idx equals the entry being allocated in the same cycle, allocation wins and done = 0.
  - Re-completing an already-done entry has no effect.
- Retire:
  - ret_valid = entry[head].valid & entry[head].done (combinational from registered state).
  - ret_* are driven from entry[head].
  - On ret_valid & ret_ready at edge: entry[head].valid/done <= 0; head <= head+1.
  - At most one retire per cycle. While ret_ready=0, outputs hold stable.
- Latency:
  - Earliest complete is the cycle after allocation.
  - Complete at edge N gives ret_valid during cycle N+1 if the entry is at head.
  - Minimum alloc-to-retire is 2 cycles.
- Simultaneous alloc and retire: both apply; count unchanged.
  - count = tail - head (IDX_W+1 bits), updated at the same edge.
- Wrap-around: the index wraps DEPTH-1 -> 0 and the wrap bit toggles; retire order stays allocation order.
- Entries with has_rd=0 retire normally. The consumer gates the RAT update and free-pool return on ret_has_rd.

Test Plan:
1. Reset, then allocate 3 entries {ard 1,2,3; pd 32,33,34; old_pd 1,2,3} -> alloc_idx 0,1,2; count 3; ret_valid 0.
2. With ret_ready=1, complete idx 2, then 0, then 1 on consecutive cycles:
   - idx 0 complete -> retire ard1/pd32/free 1 next cycle.
   - idx 1 complete -> retire ard2/free 2 next cycle.
   - idx 2 retires the cycle after that; count returns to 0.
3. Allocate 16 entries with no completes -> alloc_ready 0 at count 16; a 17th alloc_valid is ignored.
   - Complete and retire idx 0 -> alloc_ready 1 the cycle after the retire.
4. Stream 40 instructions, each completed one cycle after allocation, ret_ready=1 -> alloc_idx wraps 15->0 twice; retire sequence matches allocation order; count never exceeds 2.
5. Head done, ret_ready=0 for 5 cycles -> ret_valid 1 with payload stable and head unchanged; ret_ready=1 -> exactly one retire.
6. Allocate SW (has_rd 0), complete it -> ret_valid 1 with ret_has_rd 0.
   - Assert rst asynchronously with 4 entries live -> outputs take reset values immediately; no ret_valid after release.
